alu_serial_sequencer: RTL and testbench

- Bit-serial controller that wraps the existing 1-bit ALU slice.
- Accepts WIDTH-bit operands and a 3-bit op through a valid/ready handshake.
- Drives the slice one bit per cycle, LSB first, feeding the slice's Cout back as the next Cin.
- Reassembles the result bits and presents the result plus flags through a valid/ready output handshake.
- Sits between the decode/operand stage and the slice, which remains a separate, purely combinational instance.

---
 rtl/alu_serial_pkg.sv | 23 ++
 rtl/alu_serial_slice.sv | 35 +++
 rtl/alu_serial_top.sv | 62 ++++++
 rtl/alu_serial_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_serial_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - op codes, state encoding and helpers shared by the serial ALU sequencer
package alu_serial_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XNOR  = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_NOTB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// rtl/alu_serial_slice.sv - purely combinational 1-bit ALU slice
module alu_serial_slice
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] f,
    output logic       r,
    output logic       cout
);

    logic b_eff;

    assign b_eff = (f == OP_SUB) ? ~b : b;

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (f)
            OP_ADD, OP_SUB: begin
                r    = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            OP_NOTB:  r = ~b;
            default:  r = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_top.sv
// rtl/alu_serial_top.sv - thin wrapper tying the serial sequencer to its 1-bit ALU slice
module alu_serial_top
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    logic       slice_a;
    logic       slice_b;
    logic       slice_cin;
    logic [2:0] slice_f;
    logic       slice_r;
    logic       slice_cout;

    alu_serial_sequencer #(.WIDTH(WIDTH)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .busy       (busy),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_f    (slice_f),
        .slice_r    (slice_r),
        .slice_cout (slice_cout)
    );

    alu_serial_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .f    (slice_f),
        .r    (slice_r),
        .cout (slice_cout)
    );

endmodule

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial LSB-first sequencer around a 1-bit ALU slice; flags need ALU_SERIAL_FLAGS_EN
module alu_serial_sequencer
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_f,
    input  logic             slice_r,
    input  logic             slice_cout
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             last_bit;

    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign in_ready   = (state == IDLE) && !reset;
    assign busy       = (state == RUN);
    assign out_valid  = (state == DONE);
    assign out_result = result;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is built as A + ~B + 1 on the slice's ADD function so the borrow chains through cout.
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_f   = OP_ADD;
        if (state == RUN) begin
            slice_a   = a_sh[0];
            slice_b   = b_sh[0] ^ (op_r == OP_SUB);
            slice_cin = is_arith(op_r) & carry;
            slice_f   = is_arith(op_r) ? OP_ADD : op_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            op_r   <= OP_ADD;
            cnt    <= '0;
            carry  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        op_r  <= in_op;
                        cnt   <= '0;
                        carry <= (in_op == OP_SUB);
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    result <= {slice_r, result[WIDTH-1:1]};
                    carry  <= slice_cout;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic carry_prev;

    // After the last RUN edge, carry is the MSB carry-out and carry_prev the MSB carry-in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_prev <= 1'b0;
        end else if (state == RUN) begin
            carry_prev <= carry;
        end
    end

    assign out_zero  = (result == '0);
    assign out_carry = is_arith(op_r) & carry;
    assign out_ovf   = is_arith(op_r) & (carry ^ carry_prev);
`else
    assign out_zero  = 1'b0;
    assign out_carry = 1'b0;
    assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb/tb_alu_serial_sequencer.sv - self-checking bench for alu_serial_sequencer with an external slice
module tb_alu_serial_sequencer;
    import alu_serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_carry;
    logic         out_ovf;
    logic         busy;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic [2:0]   slice_f;
    logic         slice_r;
    logic         slice_cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           acc;
    } txn_t;

    txn_t sb_q[$];
    bit   prev_valid = 1'b0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .busy       (busy),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_f    (slice_f),
        .slice_r    (slice_r),
        .slice_cout (slice_cout)
    );

    alu_serial_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .f    (slice_f),
        .r    (slice_r),
        .cout (slice_cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: {ovf, carry, zero, result}
    function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            default:  r = ~b;
        endcase
`ifdef ALU_SERIAL_FLAGS_EN
        return {v, c, (r == '0), r};
`else
        return {3'b000, r};
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) sb_q.push_back('{op: in_op, a: in_a, b: in_b, acc: cyc});
        end
    end

    always @(negedge clk) begin
        logic [W+2:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = model(sb_q[0].op, sb_q[0].a, sb_q[0].b);
                    check("m_result", out_result, e[W-1:0]);
                    check("m_zero", out_zero, e[W]);
                    check("m_carry", out_carry, e[W+1]);
                    check("m_ovf", out_ovf, e[W+2]);
                    check("m_in_ready_done", in_ready, 1'b0);
                    if (!prev_valid) check("m_latency", cyc - sb_q[0].acc, W);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic flags(input string name, input logic z, input logic c, input logic v);
`ifdef ALU_SERIAL_FLAGS_EN
        check({name, "_zero"}, out_zero, z);
        check({name, "_carry"}, out_carry, c);
        check({name, "_ovf"}, out_ovf, v);
`else
        check({name, "_zero"}, out_zero, 1'b0);
        check({name, "_carry"}, out_carry, 1'b0);
        check({name, "_ovf"}, out_ovf, 1'b0);
`endif
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r, input int hold, input bit poke);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_busy"}, busy, 1'b1);
        if (poke) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = OP_OR;
            in_a     = ~a;
            in_b     = 8'h55;
            #1;
            check({name, "_in_ready_run"}, in_ready, 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_seen"}, out_valid, 1'b1);
        check({name, "_result"}, out_result, exp_r);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({name, "_bp_valid"}, out_valid, 1'b1);
            check({name, "_bp_result"}, out_result, exp_r);
            check({name, "_bp_in_ready"}, in_ready, 1'b0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, "_released"}, out_valid, 1'b0);
        check({name, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = OP_ADD;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", out_result, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 1'b0);
        flags("add_ovf", 1'b0, 1'b0, 1'b1);
        do_op("sub_zero", OP_SUB, 8'h05, 8'h05, 8'h00, 0, 1'b0);
        flags("sub_zero", 1'b1, 1'b1, 1'b0);
        do_op("sub_borrow", OP_SUB, 8'h00, 8'h01, 8'hFF, 0, 1'b0);
        flags("sub_borrow", 1'b0, 1'b0, 1'b0);
        do_op("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 1'b0);
        flags("and", 1'b0, 1'b0, 1'b0);
        do_op("xnor", OP_XNOR, 8'hAA, 8'h0F, 8'h5A, 0, 1'b0);
        flags("xnor", 1'b0, 1'b0, 1'b0);
        do_op("notb", OP_NOTB, 8'h00, 8'h0F, 8'hF0, 0, 1'b0);
        do_op("passa", OP_PASSA, 8'hC3, 8'h00, 8'hC3, 0, 1'b0);
        do_op("nota", OP_NOTA, 8'h3C, 8'hFF, 8'hC3, 0, 1'b0);
        do_op("or", OP_OR, 8'h81, 8'h18, 8'h99, 0, 1'b0);
        do_op("add_carry", OP_ADD, 8'hFF, 8'h01, 8'h00, 0, 1'b0);
        flags("add_carry", 1'b1, 1'b1, 1'b0);
        do_op("sub_sovf", OP_SUB, 8'h80, 8'h01, 8'h7F, 0, 1'b0);
        flags("sub_sovf", 1'b0, 1'b1, 1'b1);
        do_op("bp_add", OP_ADD, 8'h12, 8'h34, 8'h46, 3, 1'b0);
        do_op("poke_sub", OP_SUB, 8'h40, 8'h10, 8'h30, 0, 1'b1);

        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 8'h10;
        in_b     = 8'h20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_result", out_result, 8'h00);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_carry", out_carry, 1'b0);
        check("mid_rst_ovf", out_ovf, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 1'b0);
        end
        do_op("add_after_rst", OP_ADD, 8'h01, 8'h02, 8'h03, 0, 1'b0);
        flags("add_after_rst", 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
